fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Run-control and next-PC arbiter for the instruction fetch stage.
- Owns the program counter and decides on each cycle whether fetch advances, stalls or redirects. Sources are branch, jump, hazard stall and sequential.
- Sequences execution through idle/run/single-step/pause/halt, driven by debug commands from the UART front end.
- Drives the fetch memory enable, pipeline enable and flush, and reports a retired-fetch counter.

Parameters:
- PC_W, 10, width of PC, branch and jump targets (instruction-word index).
- HALT_OPC, 6'b111111, opcode field (instr[31:26]) that halts the machine.
- CNT_W, 32, width of fetch counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- cmdRun  in  1  pulse: enter/resume continuous run.
- cmdStep  in  1  pulse: advance exactly one fetch cycle.
- cmdPause  in  1  pulse: stop after current cycle.
- hazardFlag  in  1  load-use stall request from decode.
- branchFlag  in  1  branch taken, resolved in execute.
- branchPC  in  PC_W  branch target.
- jumpFlag  in  1  jump decoded in ID.
- jumpPC  in  PC_W  jump target.
- instr  in  32  instruction at current PC (memory output, valid same cycle as PC).
- PC  out  PC_W  current fetch address.
- imemEn  out  1  instruction memory read enable.
- pipeEn  out  1  pipeline register enable (global freeze when 0).
- flush  out  1  kill IF/ID (and ID/EX on branch) this cycle.
- stall  out  1  PC held due to hazard.
- halted  out  1  HALT state.
- state  out  3  encoded FSM state.
- fetchCount  out  CNT_W  number of advancing cycles with sequential or redirect PC update.

Behaviour:
Reset (synchronous, highest priority, valid any state):
- PC=0, state=IDLE, fetchCount=0, all single-bit outputs 0.

States (encoding): IDLE=0, RUN=1, STEP=2, PAUSE=3, HALT=4.
- IDLE: no advance. cmdRun->RUN; else cmdStep->STEP.
- RUN: advance every cycle. Halt detect->HALT; else cmdPause->PAUSE.
- STEP: advance one cycle. Halt detect->HALT; else->PAUSE unconditionally.
- PAUSE: no advance. cmdRun->RUN; else cmdStep->STEP.
- HALT: no advance, halted=1. Exit only via reset. Commands are ignored.
- Command priority within one cycle: cmdRun > cmdStep > cmdPause.

Advancing cycle (state RUN or STEP):
- pipeEn=1, imemEn=1.
- Next-PC priority:
  - branchFlag: PC<=branchPC, flush=1.
  - else jumpFlag: PC<=jumpPC, flush=1.
  - else hazardFlag: PC holds, stall=1, flush=0.
  - else if instr[31:26]==HALT_OPC: PC holds, next state HALT.
  - else PC<=PC+1, modulo 2^PC_W (wraps 1023->0 at default).
- Redirects override halt detection, because a halt on the wrong path is discarded. A stall defers halt detection to the next advancing cycle.
- fetchCount increments on branch, jump or sequential update only. It does not increment on stall or halt detection, and wraps at 2^CNT_W.

Non-advancing states (IDLE, PAUSE, HALT):
- pipeEn=0, imemEn=0, flush=0, stall=0, PC holds.
- branchFlag, jumpFlag, hazardFlag and instr are ignored.

Output timing:
- flush, stall, pipeEn and imemEn are combinational from state and inputs for the current cycle.
- PC, state, halted and fetchCount are registered.

Test Plan:
- Reset, then cmdRun with instr=0 for 5 cycles -> PC 0,1,2,3,4,5; fetchCount=5; pipeEn=1 throughout.
- In RUN at PC=7, hazardFlag=1 for 2 cycles -> PC stays 7, stall=1 for 2 cycles, fetchCount unchanged; then PC=8.
- At PC=20: branchFlag=1 with branchPC=100 and jumpFlag=1 with jumpPC=200 in the same cycle -> PC=100, flush=1 for one cycle.
- cmdStep from PAUSE at PC=3 -> exactly one advance, PC=4, state returns to PAUSE (3); a second cmdStep -> PC=5.
- instr[31:26]=6'b111111 at PC=9 in RUN -> state=HALT, halted=1, PC remains 9; cmdRun ignored. The same halt word with branchFlag=1 -> no halt, PC=branchPC.
- Start at PC=1023 in RUN -> wraps to 0. Reset asserted in RUN at PC=50 -> next cycle PC=0, state=IDLE, fetchCount=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: run-control FSM and next-PC arbiter for the fetch stage.
// Owns the program counter, picks between branch/jump/stall/sequential
// sources and sequences idle/run/step/pause/halt from debug commands.
module fetch_sequencer #(
  parameter int          PC_W     = 10,
  parameter logic [5:0]  HALT_OPC = 6'b111111,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmdRun,
  input  logic             cmdStep,
  input  logic             cmdPause,
  input  logic             hazardFlag,
  input  logic             branchFlag,
  input  logic [PC_W-1:0]  branchPC,
  input  logic             jumpFlag,
  input  logic [PC_W-1:0]  jumpPC,
  input  logic [31:0]      instr,
  output logic [PC_W-1:0]  PC,
  output logic             imemEn,
  output logic             pipeEn,
  output logic             flush,
  output logic             stall,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] fetchCount
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_STEP  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic advancing;
  logic redirect;
  logic hold_stall;
  logic halt_hit;

  // Only the opcode field matters here; the rest of the word belongs to decode.
  logic instr_unused;
  assign instr_unused = ^instr[25:0];

  // Classify the current cycle: does fetch advance, and which source wins.
  always_comb begin
    advancing  = (state_q == S_RUN) || (state_q == S_STEP);
    redirect   = advancing && (branchFlag || jumpFlag);
    // Redirects beat the stall; a stalled halt word is re-examined later.
    hold_stall = advancing && !redirect && hazardFlag;
    halt_hit   = advancing && !redirect && !hazardFlag &&
                 (instr[31:26] == HALT_OPC);
  end

  // Next-PC and retired-fetch counter selection.
  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    if (advancing) begin
      if (branchFlag) begin
        pc_d  = branchPC;
        cnt_d = cnt_q + CNT_ONE;
      end else if (jumpFlag) begin
        pc_d  = jumpPC;
        cnt_d = cnt_q + CNT_ONE;
      end else if (hazardFlag || halt_hit) begin
        pc_d  = pc_q;
      end else begin
        pc_d  = pc_q + PC_ONE;
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // Run-control state transitions; cmdRun beats cmdStep beats cmdPause.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_PAUSE: begin
        if (cmdRun)       state_d = S_RUN;
        else if (cmdStep) state_d = S_STEP;
      end
      S_RUN: begin
        if (halt_hit)      state_d = S_HALT;
        else if (cmdRun)   state_d = S_RUN;
        else if (cmdStep)  state_d = S_STEP;
        else if (cmdPause) state_d = S_PAUSE;
      end
      S_STEP: begin
        if (halt_hit) state_d = S_HALT;
        else          state_d = S_PAUSE;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PC         = pc_q;
  assign state      = state_q;
  assign fetchCount = cnt_q;
  assign halted     = (state_q == S_HALT);
  assign pipeEn     = advancing;
  assign imemEn     = advancing;
  assign flush      = redirect;
  assign stall      = hold_stall;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scenario tasks drive per-cycle vectors; each vector's
// expectation goes through a scoreboard queue and is checked inline.
module tb_fetch_sequencer;

  localparam logic [31:0] HW = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        reset, cmdRun, cmdStep, cmdPause;
  logic        hazardFlag, branchFlag, jumpFlag;
  logic [9:0]  branchPC, jumpPC;
  logic [31:0] instr;
  logic [9:0]  PC;
  logic        imemEn, pipeEn, flush, stall, halted;
  logic [2:0]  state;
  logic [31:0] fetchCount;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic rst, run, step, pause, haz, br, jmp;
    logic [9:0]  bpc, jpc;
    logic [31:0] ins;
    logic [9:0]  pc;
    logic [2:0]  st;
    logic [31:0] cnt;
    logic fl, sl, pe, hl, cc;
  } vec_t;

  vec_t vq[$];
  vec_t sb[$];

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .cmdRun(cmdRun), .cmdStep(cmdStep),
    .cmdPause(cmdPause), .hazardFlag(hazardFlag), .branchFlag(branchFlag),
    .branchPC(branchPC), .jumpFlag(jumpFlag), .jumpPC(jumpPC), .instr(instr),
    .PC(PC), .imemEn(imemEn), .pipeEn(pipeEn), .flush(flush), .stall(stall),
    .halted(halted), .state(state), .fetchCount(fetchCount)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Queue one cycle of stimulus with its expected outcome.
  // Inputs: rst run step pause haz br bpc jmp jpc ins
  // Expect: pc st cnt (after edge) fl sl pe (this cycle) hl cc (check comb)
  function automatic void add(logic rst, logic run, logic step, logic pause,
                              logic haz, logic br, logic [9:0] bpc, logic jmp,
                              logic [9:0] jpc, logic [31:0] ins,
                              logic [9:0] pc, logic [2:0] st, logic [31:0] cnt,
                              logic fl, logic sl, logic pe, logic hl, logic cc);
    vec_t v;
    v.rst = rst; v.run = run; v.step = step; v.pause = pause; v.haz = haz;
    v.br = br; v.bpc = bpc; v.jmp = jmp; v.jpc = jpc; v.ins = ins;
    v.pc = pc; v.st = st; v.cnt = cnt; v.fl = fl; v.sl = sl; v.pe = pe;
    v.hl = hl; v.cc = cc;
    vq.push_back(v);
  endfunction

  task automatic apply(input vec_t v);
    reset = v.rst; cmdRun = v.run; cmdStep = v.step; cmdPause = v.pause;
    hazardFlag = v.haz; branchFlag = v.br; branchPC = v.bpc;
    jumpFlag = v.jmp; jumpPC = v.jpc; instr = v.ins;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply('{rst:1, run:1, step:0, pause:0, haz:1, br:1, jmp:1, bpc:10'd9,
            jpc:10'd9, ins:HW, default:'0});
    tick();
    reset = 1'b0; cmdRun = 1'b0;
    #1;
    checks++;
    if ({PC, state, fetchCount} !== {10'd0, 3'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_regs: PC=%0d state=%0d cnt=%0d, want 0/0/0", PC, state, fetchCount);
    end
    checks++;
    if ({halted, pipeEn, imemEn, flush, stall} !== 5'b0) begin
      errors++;
      $display("FAIL reset_bits: halted/pipeEn/imemEn/flush/stall=%b%b%b%b%b, want 00000",
               halted, pipeEn, imemEn, flush, stall);
    end
    $display("[reset] PC=%0d state=%0d cnt=%0d", PC, state, fetchCount);
    hazardFlag = 0; branchFlag = 0; jumpFlag = 0; instr = 0;
    tick();
  endtask

  task automatic test_run_sequential();
    vec_t v, e;
    add(0,1,0,0,0,0,0,0,0,0, 10'd0,3'd1,32'd0, 0,0,0,0,1);
    for (int i = 0; i < 5; i++)
      add(0,0,0,0,0,0,0,0,0,0, 10'(i+1),3'd1,32'(i+1), 0,0,1,0,1);
    while (vq.size() > 0) begin
      v = vq.pop_front(); apply(v); sb.push_back(v); #1;
      e = sb.pop_front();
      if (e.cc) begin
        checks++;
        if ({flush, stall, pipeEn, imemEn} !== {e.fl, e.sl, e.pe, e.pe}) begin
          errors++;
          $display("FAIL run_comb: fl/sl/pe/ie=%b%b%b%b want %b%b%b%b",
                   flush, stall, pipeEn, imemEn, e.fl, e.sl, e.pe, e.pe);
        end
      end
      tick();
      checks++;
      if ({PC, state, fetchCount, halted} !== {e.pc, e.st, e.cnt, e.hl}) begin
        errors++;
        $display("FAIL run_regs: PC=%0d st=%0d cnt=%0d h=%b want %0d/%0d/%0d/%b",
                 PC, state, fetchCount, halted, e.pc, e.st, e.cnt, e.hl);
      end
      $display("[run] PC=%0d state=%0d cnt=%0d", PC, state, fetchCount);
    end
  endtask

  task automatic test_hazard();
    vec_t v, e;
    add(0,0,0,0,0,0,0,0,0,0,  10'd6,3'd1,32'd6, 0,0,1,0,1);
    add(0,0,0,0,0,0,0,0,0,0,  10'd7,3'd1,32'd7, 0,0,1,0,1);
    add(0,0,0,0,1,0,0,0,0,0,  10'd7,3'd1,32'd7, 0,1,1,0,1);
    add(0,0,0,0,1,0,0,0,0,0,  10'd7,3'd1,32'd7, 0,1,1,0,1);
    add(0,0,0,0,1,0,0,0,0,HW, 10'd7,3'd1,32'd7, 0,1,1,0,1);
    add(0,0,0,0,0,0,0,0,0,0,  10'd8,3'd1,32'd8, 0,0,1,0,1);
    while (vq.size() > 0) begin
      v = vq.pop_front(); apply(v); sb.push_back(v); #1;
      e = sb.pop_front();
      if (e.cc) begin
        checks++;
        if ({flush, stall, pipeEn, imemEn} !== {e.fl, e.sl, e.pe, e.pe}) begin
          errors++;
          $display("FAIL hazard_comb: fl/sl/pe/ie=%b%b%b%b want %b%b%b%b",
                   flush, stall, pipeEn, imemEn, e.fl, e.sl, e.pe, e.pe);
        end
      end
      tick();
      checks++;
      if ({PC, state, fetchCount, halted} !== {e.pc, e.st, e.cnt, e.hl}) begin
        errors++;
        $display("FAIL hazard_regs: PC=%0d st=%0d cnt=%0d h=%b want %0d/%0d/%0d/%b",
                 PC, state, fetchCount, halted, e.pc, e.st, e.cnt, e.hl);
      end
      $display("[hazard] PC=%0d state=%0d cnt=%0d stall=%b", PC, state, fetchCount, e.sl);
    end
  endtask

  task automatic test_redirect();
    vec_t v, e;
    add(0,0,0,0,0,1,10'd20,0,10'd0,0,    10'd20,3'd1,32'd9,   1,0,1,0,1);
    add(0,0,0,0,0,1,10'd100,1,10'd200,0, 10'd100,3'd1,32'd10, 1,0,1,0,1);
    add(0,0,0,0,0,0,10'd0,1,10'd200,0,   10'd200,3'd1,32'd11, 1,0,1,0,1);
    add(0,0,0,0,0,0,10'd0,0,10'd0,0,     10'd201,3'd1,32'd12, 0,0,1,0,1);
    add(0,0,0,0,1,1,10'd2,0,10'd0,0,     10'd2,3'd1,32'd13,   1,0,1,0,1);
    while (vq.size() > 0) begin
      v = vq.pop_front(); apply(v); sb.push_back(v); #1;
      e = sb.pop_front();
      if (e.cc) begin
        checks++;
        if ({flush, stall, pipeEn, imemEn} !== {e.fl, e.sl, e.pe, e.pe}) begin
          errors++;
          $display("FAIL redirect_comb: fl/sl/pe/ie=%b%b%b%b want %b%b%b%b",
                   flush, stall, pipeEn, imemEn, e.fl, e.sl, e.pe, e.pe);
        end
      end
      tick();
      checks++;
      if ({PC, state, fetchCount, halted} !== {e.pc, e.st, e.cnt, e.hl}) begin
        errors++;
        $display("FAIL redirect_regs: PC=%0d st=%0d cnt=%0d h=%b want %0d/%0d/%0d/%b",
                 PC, state, fetchCount, halted, e.pc, e.st, e.cnt, e.hl);
      end
      $display("[redirect] PC=%0d state=%0d cnt=%0d flush=%b", PC, state, fetchCount, e.fl);
    end
  endtask

  task automatic test_step();
    vec_t v, e;
    add(0,0,0,1,0,0,10'd0,0,0,0,  10'd3,3'd3,32'd14, 0,0,1,0,1);
    add(0,0,0,0,1,1,10'd77,1,0,0, 10'd3,3'd3,32'd14, 0,0,0,0,1);
    add(0,0,1,0,0,0,10'd0,0,0,0,  10'd3,3'd2,32'd14, 0,0,0,0,1);
    add(0,0,0,0,0,0,10'd0,0,0,0,  10'd4,3'd3,32'd15, 0,0,1,0,1);
    add(0,0,1,0,0,0,10'd0,0,0,0,  10'd4,3'd2,32'd15, 0,0,0,0,1);
    add(0,0,0,0,0,0,10'd0,0,0,0,  10'd5,3'd3,32'd16, 0,0,1,0,1);
    add(0,1,1,0,0,0,10'd0,0,0,0,  10'd5,3'd1,32'd16, 0,0,0,0,1);
    add(0,1,0,1,0,0,10'd0,0,0,0,  10'd6,3'd1,32'd17, 0,0,1,0,1);
    add(0,0,0,1,0,0,10'd0,0,0,0,  10'd7,3'd3,32'd18, 0,0,1,0,1);
    while (vq.size() > 0) begin
      v = vq.pop_front(); apply(v); sb.push_back(v); #1;
      e = sb.pop_front();
      if (e.cc) begin
        checks++;
        if ({flush, stall, pipeEn, imemEn} !== {e.fl, e.sl, e.pe, e.pe}) begin
          errors++;
          $display("FAIL step_comb: fl/sl/pe/ie=%b%b%b%b want %b%b%b%b",
                   flush, stall, pipeEn, imemEn, e.fl, e.sl, e.pe, e.pe);
        end
      end
      tick();
      checks++;
      if ({PC, state, fetchCount, halted} !== {e.pc, e.st, e.cnt, e.hl}) begin
        errors++;
        $display("FAIL step_regs: PC=%0d st=%0d cnt=%0d h=%b want %0d/%0d/%0d/%b",
                 PC, state, fetchCount, halted, e.pc, e.st, e.cnt, e.hl);
      end
      $display("[step] PC=%0d state=%0d cnt=%0d", PC, state, fetchCount);
    end
  endtask

  task automatic test_halt();
    vec_t v, e;
    add(0,1,0,0,0,0,10'd0,0,0,0,   10'd7,3'd1,32'd18, 0,0,0,0,1);
    add(0,0,0,0,0,0,10'd0,0,0,0,   10'd8,3'd1,32'd19, 0,0,1,0,1);
    add(0,0,0,0,0,1,10'd9,0,0,HW,  10'd9,3'd1,32'd20, 1,0,1,0,1);
    add(0,0,0,0,0,0,10'd0,0,0,HW,  10'd9,3'd4,32'd20, 0,0,1,1,1);
    add(0,1,0,0,1,1,10'd50,0,0,HW, 10'd9,3'd4,32'd20, 0,0,0,1,1);
    add(0,0,1,0,0,0,10'd0,0,0,0,   10'd9,3'd4,32'd20, 0,0,0,1,1);
    while (vq.size() > 0) begin
      v = vq.pop_front(); apply(v); sb.push_back(v); #1;
      e = sb.pop_front();
      if (e.cc) begin
        checks++;
        if ({flush, stall, pipeEn, imemEn} !== {e.fl, e.sl, e.pe, e.pe}) begin
          errors++;
          $display("FAIL halt_comb: fl/sl/pe/ie=%b%b%b%b want %b%b%b%b",
                   flush, stall, pipeEn, imemEn, e.fl, e.sl, e.pe, e.pe);
        end
      end
      tick();
      checks++;
      if ({PC, state, fetchCount, halted} !== {e.pc, e.st, e.cnt, e.hl}) begin
        errors++;
        $display("FAIL halt_regs: PC=%0d st=%0d cnt=%0d h=%b want %0d/%0d/%0d/%b",
                 PC, state, fetchCount, halted, e.pc, e.st, e.cnt, e.hl);
      end
      $display("[halt] PC=%0d state=%0d cnt=%0d halted=%b", PC, state, fetchCount, halted);
    end
  endtask

  task automatic test_wrap_reset();
    vec_t v, e;
    add(1,0,0,0,0,0,10'd0,0,0,0,    10'd0,3'd0,32'd0,    0,0,0,0,0);
    add(0,1,0,0,0,0,10'd0,0,0,0,    10'd0,3'd1,32'd0,    0,0,0,0,1);
    add(0,0,0,0,0,1,10'd1023,0,0,0, 10'd1023,3'd1,32'd1, 1,0,1,0,1);
    add(0,0,0,0,0,0,10'd0,0,0,0,    10'd0,3'd1,32'd2,    0,0,1,0,1);
    add(0,0,0,0,0,1,10'd50,0,0,0,   10'd50,3'd1,32'd3,   1,0,1,0,1);
    add(1,1,0,0,0,1,10'd7,0,0,0,    10'd0,3'd0,32'd0,    0,0,0,0,0);
    add(0,0,0,0,1,1,10'd7,0,0,0,    10'd0,3'd0,32'd0,    0,0,0,0,1);
    add(0,0,1,0,0,0,10'd0,0,0,0,    10'd0,3'd2,32'd0,    0,0,0,0,1);
    add(0,0,0,0,0,0,10'd0,0,0,0,    10'd1,3'd3,32'd1,    0,0,1,0,1);
    while (vq.size() > 0) begin
      v = vq.pop_front(); apply(v); sb.push_back(v); #1;
      e = sb.pop_front();
      if (e.cc) begin
        checks++;
        if ({flush, stall, pipeEn, imemEn} !== {e.fl, e.sl, e.pe, e.pe}) begin
          errors++;
          $display("FAIL wrap_comb: fl/sl/pe/ie=%b%b%b%b want %b%b%b%b",
                   flush, stall, pipeEn, imemEn, e.fl, e.sl, e.pe, e.pe);
        end
      end
      tick();
      checks++;
      if ({PC, state, fetchCount, halted} !== {e.pc, e.st, e.cnt, e.hl}) begin
        errors++;
        $display("FAIL wrap_regs: PC=%0d st=%0d cnt=%0d h=%b want %0d/%0d/%0d/%b",
                 PC, state, fetchCount, halted, e.pc, e.st, e.cnt, e.hl);
      end
      $display("[wrap] PC=%0d state=%0d cnt=%0d", PC, state, fetchCount);
    end
  endtask

  initial begin
    reset = 1'b1; cmdRun = 0; cmdStep = 0; cmdPause = 0;
    hazardFlag = 0; branchFlag = 0; jumpFlag = 0;
    branchPC = '0; jumpPC = '0; instr = '0;
    tick();
    test_reset();
    test_run_sequential();
    test_hazard();
    test_redirect();
    test_step();
    test_halt();
    test_wrap_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
